// File: rtl/lsu_stb_rwptr_ctl.sv
// Per-thread store-buffer allocation/retirement controller: 8-entry circular
// buffer with write/read pointers, valid bits, occupancy, W-stage rollback.
module lsu_stb_rwptr_ctl (
   input  logic       rclk,
   input  logic       reset,
   input  logic       se,
   input  logic       st_inst_vld_m,
   input  logic       st_flush_w,
   input  logic       stb_ack_vld,
   output logic [7:0] stb_clk_en_l,
   output logic [2:0] stb_wptr,
   output logic [2:0] stb_rptr,
   output logic [7:0] stb_valid,
   output logic [3:0] stb_cnt,
   output logic       stb_full,
   output logic       stb_empty,
   output logic       stb_alloc_ovfl
);

   logic       alloc_m;
   logic       flush_hit;
   logic       ack_hit;
   logic       alloc_w_q;
   logic [2:0] w_idx_q;
   logic [7:0] valid_nxt;
   logic [3:0] cnt_nxt;

   assign alloc_m   = st_inst_vld_m & ~stb_full & ~st_flush_w & ~reset;
   assign flush_hit = st_flush_w & alloc_w_q;
   // The oldest entry cannot retire while it is still the uncommitted W-stage store.
   assign ack_hit   = stb_ack_vld & ~stb_empty & ~(alloc_w_q & (w_idx_q == stb_rptr));

   always_comb begin
      stb_clk_en_l = 8'hFF;
      for (int i = 0; i < 8; i++) begin
         stb_clk_en_l[i] = ~((alloc_m & (stb_wptr == 3'(i))) | se);
      end
   end

   always_comb begin
      valid_nxt = stb_valid;
      if (alloc_m)   valid_nxt[stb_wptr] = 1'b1;
      if (flush_hit) valid_nxt[w_idx_q]  = 1'b0;
      if (ack_hit)   valid_nxt[stb_rptr] = 1'b0;
   end

   assign cnt_nxt = stb_cnt + {3'b000, alloc_m} - {3'b000, flush_hit} - {3'b000, ack_hit};

   always_ff @(posedge rclk) begin
      if (reset) begin
         stb_wptr       <= 3'd0;
         stb_rptr       <= 3'd0;
         stb_valid      <= 8'h00;
         stb_cnt        <= 4'd0;
         stb_full       <= 1'b0;
         stb_empty      <= 1'b1;
         stb_alloc_ovfl <= 1'b0;
         alloc_w_q      <= 1'b0;
         w_idx_q        <= 3'd0;
      end else begin
         if (flush_hit)    stb_wptr <= w_idx_q;
         else if (alloc_m) stb_wptr <= stb_wptr + 3'd1;
         if (ack_hit)      stb_rptr <= stb_rptr + 3'd1;
         if (alloc_m)      w_idx_q  <= stb_wptr;
         alloc_w_q      <= alloc_m;
         stb_valid      <= valid_nxt;
         stb_cnt        <= cnt_nxt;
         stb_full       <= (cnt_nxt == 4'd8);
         stb_empty      <= (cnt_nxt == 4'd0);
         // Full is registered, so a store in the same cycle as a freeing ack still overflows.
         stb_alloc_ovfl <= st_inst_vld_m & stb_full & ~st_flush_w;
      end
   end

endmodule

// File: tb/tb_lsu_stb_rwptr_ctl.sv
// Directed bench for lsu_stb_rwptr_ctl: fill/wrap, overflow, flush rollback,
// ack filtering, scan enable and reset with live entries.
module tb_lsu_stb_rwptr_ctl;

   logic       rclk = 1'b0;
   logic       reset, se, st_inst_vld_m, st_flush_w, stb_ack_vld;
   logic [7:0] stb_clk_en_l;
   logic [2:0] stb_wptr, stb_rptr;
   logic [7:0] stb_valid;
   logic [3:0] stb_cnt;
   logic       stb_full, stb_empty, stb_alloc_ovfl;

   int vectors = 0;
   int errors  = 0;

   // {wptr, rptr, valid, cnt, full, empty, ovfl}
   logic [22:0] obs;
   logic [22:0] exp_st;
   logic [7:0]  exp_en;

   lsu_stb_rwptr_ctl dut (
      .rclk           (rclk),
      .reset          (reset),
      .se             (se),
      .st_inst_vld_m  (st_inst_vld_m),
      .st_flush_w     (st_flush_w),
      .stb_ack_vld    (stb_ack_vld),
      .stb_clk_en_l   (stb_clk_en_l),
      .stb_wptr       (stb_wptr),
      .stb_rptr       (stb_rptr),
      .stb_valid      (stb_valid),
      .stb_cnt        (stb_cnt),
      .stb_full       (stb_full),
      .stb_empty      (stb_empty),
      .stb_alloc_ovfl (stb_alloc_ovfl)
   );

   always #5 rclk = ~rclk;

   assign obs = {stb_wptr, stb_rptr, stb_valid, stb_cnt, stb_full, stb_empty, stb_alloc_ovfl};

   task automatic tick();
      @(posedge rclk);
      #1;
   endtask

   task automatic drive(input logic st, input logic fl, input logic ack, input logic s);
      st_inst_vld_m = st;
      st_flush_w    = fl;
      stb_ack_vld   = ack;
      se            = s;
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hFF) begin
         errors++;
         $display("FAIL reset_clk_en actual=%h required=%h", stb_clk_en_l, 8'hFF);
      end
      tick(); tick();
      exp_st = {3'd0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL reset_state actual=%h required=%h", obs, exp_st);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 8; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         exp_en = ~(8'h01 << i);
         vectors++;
         if (stb_clk_en_l !== exp_en) begin
            errors++;
            $display("FAIL fill_clk_en[%0d] actual=%h required=%h", i, stb_clk_en_l, exp_en);
         end
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp_st = {3'd0, 3'd0, 8'hFF, 4'd8, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL fill_full_state actual=%h required=%h", obs, exp_st);
      end
   endtask

   task automatic test_overflow();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hFF) begin
         errors++;
         $display("FAIL ovfl_clk_en actual=%h required=%h", stb_clk_en_l, 8'hFF);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp_st = {3'd0, 3'd1, 8'hFE, 4'd7, 1'b0, 1'b0, 1'b1};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL ovfl_pulse_state actual=%h required=%h", obs, exp_st);
      end
      tick();
      exp_st = {3'd0, 3'd1, 8'hFE, 4'd7, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL ovfl_pulse_end actual=%h required=%h", obs, exp_st);
      end
   endtask

   task automatic test_flush();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hF7) begin
         errors++;
         $display("FAIL flush_alloc3_clk_en actual=%h required=%h", stb_clk_en_l, 8'hF7);
      end
      tick();
      // flush of entry 3 also kills the M-stage store presented alongside it
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hFF) begin
         errors++;
         $display("FAIL flush_kill_clk_en actual=%h required=%h", stb_clk_en_l, 8'hFF);
      end
      tick();
      exp_st = {3'd3, 3'd0, 8'h07, 4'd3, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL flush_rollback actual=%h required=%h", obs, exp_st);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hF7) begin
         errors++;
         $display("FAIL flush_reuse_clk_en actual=%h required=%h", stb_clk_en_l, 8'hF7);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      exp_st = {3'd4, 3'd0, 8'h0F, 4'd4, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL flush_without_alloc actual=%h required=%h", obs, exp_st);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      tick();
      exp_st = {3'd4, 3'd1, 8'h0E, 4'd3, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL flush_plus_ack actual=%h required=%h", obs, exp_st);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_empty_ack();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      exp_st = {3'd0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL empty_ack_ignored actual=%h required=%h", obs, exp_st);
      end
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      tick();
      exp_st = {3'd1, 3'd0, 8'h01, 4'd1, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL ack_in_w_ignored actual=%h required=%h", obs, exp_st);
      end
      tick();
      exp_st = {3'd1, 3'd1, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL ack_retire actual=%h required=%h", obs, exp_st);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      tick();
      drive(1'b1, 1'b0, 1'b1, 1'b0);
      vectors++;
      if (stb_clk_en_l !== 8'hF7) begin
         errors++;
         $display("FAIL b2b_clk_en actual=%h required=%h", stb_clk_en_l, 8'hF7);
      end
      tick();
      exp_st = {3'd4, 3'd2, 8'h0C, 4'd2, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL b2b_alloc_ack actual=%h required=%h", obs, exp_st);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_scan();
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (stb_clk_en_l !== 8'h00) begin
         errors++;
         $display("FAIL scan_clk_en actual=%h required=%h", stb_clk_en_l, 8'h00);
      end
      tick();
      exp_st = {3'd4, 3'd2, 8'h0C, 4'd2, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL scan_state_hold actual=%h required=%h", obs, exp_st);
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 1'b0, 1'b0, 1'b0);
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      exp_st = {3'd7, 3'd2, 8'h7C, 4'd5, 1'b0, 1'b0, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL five_valid actual=%h required=%h", obs, exp_st);
      end
      reset = 1'b1;
      drive(1'b1, 1'b0, 1'b0, 1'b1);
      vectors++;
      if (stb_clk_en_l !== 8'h00) begin
         errors++;
         $display("FAIL reset_scan_clk_en actual=%h required=%h", stb_clk_en_l, 8'h00);
      end
      tick();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      reset = 1'b0;
      exp_st = {3'd0, 3'd0, 8'h00, 4'd0, 1'b0, 1'b1, 1'b0};
      vectors++;
      if (obs !== exp_st) begin
         errors++;
         $display("FAIL reset_mid_state actual=%h required=%h", obs, exp_st);
      end
   endtask

   initial begin
      reset = 1'b1;
      se = 1'b0;
      st_inst_vld_m = 1'b0;
      st_flush_w = 1'b0;
      stb_ack_vld = 1'b0;
      tick();
      test_reset();
      test_fill();
      test_overflow();
      test_flush();
      test_empty_ack();
      test_back_to_back();
      test_scan();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
